// File: rtl/clk_div_ctrl.sv
// Run-time clock divider: produces a divided clock and a per-period tick, and swaps in
// new divide factors only on period boundaries so the output never shows a runt pulse.
module clk_div_ctrl #(
    parameter int WIDTH          = 32,
    parameter int DEFAULT_FACTOR = 100,
    parameter int MIN_FACTOR     = 2
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] cfgFactor,
    input  logic             cfgValid,
    output logic             cfgReady,
    output logic             cfgError,
    output logic [WIDTH-1:0] activeFactor,
    output logic             clkOut,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] DEFAULT_F = WIDTH'(DEFAULT_FACTOR);
    localparam logic [WIDTH-1:0] MIN_F     = WIDTH'(MIN_FACTOR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } stateT;

    stateT            state;
    stateT            nextState;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] pendFactor;
    logic             stopReq;

    logic             transfer;
    logic             badReq;
    logic             goodReq;
    logic             boundary;

    assign transfer = cfgValid && cfgReady;
    assign badReq   = transfer && (cfgFactor < MIN_F);
    assign goodReq  = transfer && !badReq;
    assign boundary = (state != IDLE) && (counter == activeFactor - WIDTH'(1));

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A request landing on a stopping boundary still goes idle; the factor is applied there.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (!transfer && enable) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (boundary && stopReq) begin
                    nextState = IDLE;
                end else if (goodReq) begin
                    nextState = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    nextState = stopReq ? IDLE : RUN;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            counter      <= '0;
            activeFactor <= DEFAULT_F;
            pendFactor   <= '0;
            cfgError     <= 1'b0;
            stopReq      <= 1'b0;
        end else begin
            cfgError <= badReq;
            stopReq  <= (nextState != IDLE) && !enable;

            if (state == IDLE || boundary) begin
                counter <= '0;
            end else begin
                counter <= counter + WIDTH'(1);
            end

            if (state == RUN && goodReq) begin
                pendFactor <= cfgFactor;
            end

            if (state == IDLE && goodReq) begin
                activeFactor <= cfgFactor;
            end else if (state == PEND && boundary) begin
                activeFactor <= pendFactor;
            end else if (state == RUN && goodReq && boundary && stopReq) begin
                activeFactor <= cfgFactor;
            end
        end
    end

    // The low phase is floor(F/2) cycles, so odd factors spend the extra cycle high.
    always_comb begin
        busy     = (state != IDLE);
        cfgReady = (state != PEND);
        clkOut   = busy && (counter >= (activeFactor >> 1));
        tick     = boundary;
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with a 4-cycle default factor; each task covers one
// scenario and checks outputs against hand-derived waveforms.
module tb_clk_div_ctrl;

    localparam int WIDTH = 16;

    logic             clkIn;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] cfgFactor;
    logic             cfgValid;
    logic             cfgReady;
    logic             cfgError;
    logic [WIDTH-1:0] activeFactor;
    logic             clkOut;
    logic             tick;
    logic             busy;

    int errors = 0;
    int checks = 0;

    clk_div_ctrl #(
        .WIDTH(WIDTH),
        .DEFAULT_FACTOR(4),
        .MIN_FACTOR(2)
    ) dut (
        .clkIn(clkIn),
        .reset(reset),
        .enable(enable),
        .cfgFactor(cfgFactor),
        .cfgValid(cfgValid),
        .cfgReady(cfgReady),
        .cfgError(cfgError),
        .activeFactor(activeFactor),
        .clkOut(clkOut),
        .tick(tick),
        .busy(busy)
    );

    initial begin
        clkIn = 1'b0;
        forever #5 clkIn = ~clkIn;
    end

    // Advance one clock; inputs changed afterwards are seen at the following edge.
    task automatic cyc();
        @(posedge clkIn);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; cfgValid = 1'b0; cfgFactor = '0;
        cyc(); cyc();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (clkOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_clkOut got=%b exp=0", clkOut); end
        checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (cfgReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_cfgReady got=%b exp=1", cfgReady); end
        checks++; if (cfgError !== 1'b0) begin errors++; $display("[TB] FAIL reset_cfgError got=%b exp=0", cfgError); end
        checks++; if (activeFactor !== 16'd4) begin errors++; $display("[TB] FAIL reset_factor got=%0d exp=4", activeFactor); end
    endtask

    task automatic test_default_run();
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            checks++; if (clkOut !== ((i % 4) >= 2)) begin errors++; $display("[TB] FAIL run_clkOut[%0d] got=%b exp=%b", i, clkOut, ((i % 4) >= 2)); end
            checks++; if (tick !== ((i % 4) == 3)) begin errors++; $display("[TB] FAIL run_tick[%0d] got=%b exp=%b", i, tick, ((i % 4) == 3)); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL run_busy[%0d] got=%b exp=1", i, busy); end
            cyc();
        end
    endtask

    task automatic test_bad_factor();
        cfgValid = 1'b1; cfgFactor = 16'd1;
        cyc();
        cfgValid = 1'b0;
        checks++; if (cfgError !== 1'b1) begin errors++; $display("[TB] FAIL bad_errPulse got=%b exp=1", cfgError); end
        checks++; if (activeFactor !== 16'd4) begin errors++; $display("[TB] FAIL bad_factor got=%0d exp=4", activeFactor); end
        checks++; if (cfgReady !== 1'b1) begin errors++; $display("[TB] FAIL bad_ready got=%b exp=1", cfgReady); end
        checks++; if (clkOut !== 1'b0) begin errors++; $display("[TB] FAIL bad_clkOut1 got=%b exp=0", clkOut); end
        cyc();
        checks++; if (cfgError !== 1'b0) begin errors++; $display("[TB] FAIL bad_errClear got=%b exp=0", cfgError); end
        checks++; if (clkOut !== 1'b1) begin errors++; $display("[TB] FAIL bad_clkOut2 got=%b exp=1", clkOut); end
        cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL bad_tick got=%b exp=1", tick); end
        cyc();
    endtask

    task automatic test_reconfig();
        cyc();
        cfgValid = 1'b1; cfgFactor = 16'd6;
        cyc();
        cfgValid = 1'b0;
        checks++; if (cfgReady !== 1'b0) begin errors++; $display("[TB] FAIL cfg_readyLow got=%b exp=0", cfgReady); end
        checks++; if (activeFactor !== 16'd4) begin errors++; $display("[TB] FAIL cfg_factorHeld got=%0d exp=4", activeFactor); end
        checks++; if (clkOut !== 1'b1) begin errors++; $display("[TB] FAIL cfg_clkOutC2 got=%b exp=1", clkOut); end
        cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL cfg_oldTick got=%b exp=1", tick); end
        checks++; if (cfgReady !== 1'b0) begin errors++; $display("[TB] FAIL cfg_readyLow2 got=%b exp=0", cfgReady); end
        cyc();
        checks++; if (activeFactor !== 16'd6) begin errors++; $display("[TB] FAIL cfg_commit got=%0d exp=6", activeFactor); end
        checks++; if (cfgReady !== 1'b1) begin errors++; $display("[TB] FAIL cfg_readyBack got=%b exp=1", cfgReady); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (clkOut !== (i >= 3)) begin errors++; $display("[TB] FAIL cfg_clkOut[%0d] got=%b exp=%b", i, clkOut, (i >= 3)); end
            checks++; if (tick !== (i == 5)) begin errors++; $display("[TB] FAIL cfg_tick[%0d] got=%b exp=%b", i, tick, (i == 5)); end
            cyc();
        end
    endtask

    task automatic test_odd_factor();
        cfgValid = 1'b1; cfgFactor = 16'd5;
        cyc();
        cfgValid = 1'b0;
        checks++; if (activeFactor !== 16'd6) begin errors++; $display("[TB] FAIL odd_pendHeld got=%0d exp=6", activeFactor); end
        repeat (5) cyc();
        checks++; if (activeFactor !== 16'd5) begin errors++; $display("[TB] FAIL odd_commit got=%0d exp=5", activeFactor); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (clkOut !== ((i % 5) >= 2)) begin errors++; $display("[TB] FAIL odd_clkOut[%0d] got=%b exp=%b", i, clkOut, ((i % 5) >= 2)); end
            checks++; if (tick !== ((i % 5) == 4)) begin errors++; $display("[TB] FAIL odd_tick[%0d] got=%b exp=%b", i, tick, ((i % 5) == 4)); end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        repeat (4) cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL b2b_boundary got=%b exp=1", tick); end
        cfgValid = 1'b1; cfgFactor = 16'd4;
        cyc();
        cfgValid = 1'b0;
        checks++; if (activeFactor !== 16'd5) begin errors++; $display("[TB] FAIL b2b_noCommit got=%0d exp=5", activeFactor); end
        checks++; if (cfgReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pending got=%b exp=0", cfgReady); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (clkOut !== (i >= 2)) begin errors++; $display("[TB] FAIL b2b_clkOut[%0d] got=%b exp=%b", i, clkOut, (i >= 2)); end
            checks++; if (tick !== (i == 4)) begin errors++; $display("[TB] FAIL b2b_tick[%0d] got=%b exp=%b", i, tick, (i == 4)); end
            cyc();
        end
        checks++; if (activeFactor !== 16'd4) begin errors++; $display("[TB] FAIL b2b_commit got=%0d exp=4", activeFactor); end
    endtask

    task automatic test_stop();
        cyc();
        enable = 1'b0;
        cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL stop_stillBusy got=%b exp=1", busy); end
        checks++; if (clkOut !== 1'b1) begin errors++; $display("[TB] FAIL stop_clkOutC2 got=%b exp=1", clkOut); end
        cyc();
        checks++; if (tick !== 1'b1) begin errors++; $display("[TB] FAIL stop_finalTick got=%b exp=1", tick); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_idle got=%b exp=0", busy); end
        checks++; if (clkOut !== 1'b0) begin errors++; $display("[TB] FAIL stop_clkOutIdle got=%b exp=0", clkOut); end
        checks++; if (tick !== 1'b0) begin errors++; $display("[TB] FAIL stop_tickIdle got=%b exp=0", tick); end
        cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_stayIdle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_pend();
        enable = 1'b1;
        cyc();
        cfgValid = 1'b1; cfgFactor = 16'd6;
        cyc();
        cfgValid = 1'b0;
        checks++; if (cfgReady !== 1'b0) begin errors++; $display("[TB] FAIL rp_pending got=%b exp=0", cfgReady); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rp_idle got=%b exp=0", busy); end
        checks++; if (cfgReady !== 1'b1) begin errors++; $display("[TB] FAIL rp_ready got=%b exp=1", cfgReady); end
        checks++; if (activeFactor !== 16'd4) begin errors++; $display("[TB] FAIL rp_factor got=%0d exp=4", activeFactor); end
        cyc();
        for (int i = 0; i < 8; i++) begin
            checks++; if (clkOut !== ((i % 4) >= 2)) begin errors++; $display("[TB] FAIL rp_clkOut[%0d] got=%b exp=%b", i, clkOut, ((i % 4) >= 2)); end
            checks++; if (tick !== ((i % 4) == 3)) begin errors++; $display("[TB] FAIL rp_tick[%0d] got=%b exp=%b", i, tick, ((i % 4) == 3)); end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_bad_factor();
        test_reconfig();
        test_odd_factor();
        test_back_to_back();
        test_stop();
        test_reset_pend();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
